echo_dist_conv: RTL

- Downstream consumer of the ultrasonic ranging FSM.
- Captures the echo-width count in 1 us ticks when the FSM raises its done strobe `h`, together with the 20 ms timeout flag `full`.
- Converts the count to centimetres with a rounded, iterative restoring division by 58 us/cm, clamped to sensor range.
- Presents the result with a one-cycle valid pulse to the display/UART stage.

---
 rtl/echo_pkg.sv | 23 ++
 rtl/seq_div_restoring.sv | 79 +++++++
 rtl/echo_dist_conv.sv | 128 ++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : echo_pkg
// Purpose  : Shared constants for the echo-width to distance converter.
//            Holds the default widths, the divisor, the range clamp value and
//            the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package echo_pkg;

    localparam int CNT_W     = 15;   // echo count width, covers 20000 us
    localparam int DIST_W    = 9;    // distance output width in cm
    localparam int US_PER_CM = 58;   // round-trip microseconds per centimetre
    localparam int MAX_CM    = 400;  // sensor range limit, also the timeout value

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t DIV  = 2'b01;
    localparam state_t DONE = 2'b10;

endpackage : echo_pkg
`default_nettype wire

// File: rtl/seq_div_restoring.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_restoring
// Purpose  : Iterative restoring divider by a constant, one quotient bit per
//            clock, MSB first. NUM_W steps per division.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            start_i       - load num_i and begin a division
//            num_i         - numerator
//            done_o        - high during the cycle whose edge performs the
//                            final step; quo_o is complete after that edge
//            quo_o         - quotient, held until the next start
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_restoring #(
    parameter int NUM_W   = 16,
    parameter int DIVISOR = 58
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    output logic             done_o,
    output logic [NUM_W-1:0] quo_o
);

    // One extra bit so the shifted partial remainder (< 2*DIVISOR) fits.
    localparam int REM_W  = $clog2(DIVISOR) + 1;
    localparam int ITER_W = $clog2(NUM_W);

    localparam logic [REM_W-1:0]  C_DIV  = REM_W'(DIVISOR);
    localparam logic [ITER_W-1:0] C_LAST = ITER_W'(NUM_W - 1);
    localparam logic [ITER_W-1:0] C_ONE  = ITER_W'(1);

    logic [NUM_W-1:0]  num_q;
    logic [NUM_W-1:0]  quo_q;
    logic [REM_W-1:0]  rem_q;
    logic [ITER_W-1:0] iter_q;
    logic              run_q;

    logic [REM_W-1:0]  rem_sh;
    logic              rem_ge;

    // The stored remainder is always < DIVISOR, so its top bit is zero and
    // dropping it on the shift loses nothing.
    always_comb begin
        rem_sh = {rem_q[REM_W-2:0], num_q[NUM_W-1]};
        rem_ge = (rem_sh >= C_DIV);
    end

    assign done_o = run_q && (iter_q == C_LAST);
    assign quo_o  = quo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else if (start_i) begin
            num_q  <= num_i;
            quo_q  <= '0;
            rem_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            num_q <= {num_q[NUM_W-2:0], 1'b0};
            rem_q <= rem_ge ? (rem_sh - C_DIV) : rem_sh;
            quo_q <= {quo_q[NUM_W-2:0], rem_ge};
            if (done_o) begin
                run_q <= 1'b0;
            end else begin
                iter_q <= iter_q + C_ONE;
            end
        end
    end

endmodule : seq_div_restoring
`default_nettype wire

// File: rtl/echo_dist_conv.sv
`default_nettype none
// ============================================================================
// Module   : echo_dist_conv
// Purpose  : Captures an ultrasonic echo width (1 us ticks) and converts it to
//            centimetres, rounded half-up, clamped to the sensor range.
//            A timeout capture bypasses the divider and reports MAX_CM.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            h             - capture strobe (one cycle) from ranging FSM
//            full          - timeout flag, sampled with h
//            cnt           - echo width in us, sampled with h
//            dist_cm       - last converted distance, held
//            dist_vld      - one-cycle pulse when results update
//            out_of_range  - timeout or clamp flag, held
//            busy          - capture edge through the dist_vld cycle
// Revision : 1.0 - initial release
// ============================================================================
module echo_dist_conv
    import echo_pkg::*;
#(
    parameter int CNT_W     = echo_pkg::CNT_W,
    parameter int DIST_W    = echo_pkg::DIST_W,
    parameter int US_PER_CM = echo_pkg::US_PER_CM,
    parameter int MAX_CM    = echo_pkg::MAX_CM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h,
    input  logic              full,
    input  logic [CNT_W-1:0]  cnt,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_vld,
    output logic              out_of_range,
    output logic              busy
);

    // One extra numerator bit absorbs the rounding offset without overflow.
    localparam int NUM_W = CNT_W + 1;

    localparam logic [NUM_W-1:0]  C_HALF  = NUM_W'(US_PER_CM / 2);
    localparam logic [NUM_W-1:0]  C_MAX_Q = NUM_W'(MAX_CM);
    localparam logic [DIST_W-1:0] C_MAX_D = DIST_W'(MAX_CM);

    state_t            state_q;
    state_t            state_d;
    logic              ovf_q;
    logic [DIST_W-1:0] dist_q;
    logic              vld_q;
    logic              oor_q;

    logic              capture;
    logic              div_start;
    logic              div_done;
    logic [NUM_W-1:0]  div_num;
    logic [NUM_W-1:0]  div_quo;

    assign div_num = NUM_W'(cnt) + C_HALF;

    seq_div_restoring #(
        .NUM_W   (NUM_W),
        .DIVISOR (US_PER_CM)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (div_start),
        .num_i   (div_num),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = full ? DONE : DIV;
            DIV:     if (div_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode. The dist_vld cycle sits in IDLE but still
    // counts as busy, so a strobe arriving there must not start a capture.
    always_comb begin
        busy      = (state_q != IDLE) || vld_q;
        capture   = (state_q == IDLE) && h && !vld_q;
        div_start = capture && !full;
    end

    // Result registers: only written on the DONE edge, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            dist_q <= '0;
            vld_q  <= 1'b0;
            oor_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (capture) begin
                ovf_q <= full;
            end
            if (state_q == DONE) begin
                vld_q <= 1'b1;
                if (ovf_q || (div_quo > C_MAX_Q)) begin
                    dist_q <= C_MAX_D;
                    oor_q  <= 1'b1;
                end else begin
                    dist_q <= div_quo[DIST_W-1:0];
                    oor_q  <= 1'b0;
                end
            end
        end
    end

    assign dist_cm      = dist_q;
    assign dist_vld     = vld_q;
    assign out_of_range = oor_q;

endmodule : echo_dist_conv
`default_nettype wire
